// File: rtl/mpu_elementwise_if.sv
// Handshake and matrix bus for the element-wise MPU unit.
// The master side presents operands and takes results; the unit is the slave.
interface mpu_elementwise_if #(
    parameter int DIM    = 5,
    parameter int ELEM_W = 8
);
    localparam int NW = ELEM_W * DIM * DIM;

    logic          start_valid;
    logic          start_ready;
    logic [1:0]    op;
    logic          sat;
    logic [NW-1:0] matrix_a;
    logic [NW-1:0] matrix_b;
    logic [NW-1:0] result;
    logic          result_valid;
    logic          result_ready;
    logic          overflow;
    logic          busy;

    modport master (
        output start_valid, op, sat, matrix_a, matrix_b, result_ready,
        input  start_ready, result, result_valid, overflow, busy
    );

    modport slave (
        input  start_valid, op, sat, matrix_a, matrix_b, result_ready,
        output start_ready, result, result_valid, overflow, busy
    );
endinterface

// File: rtl/mpu_elementwise.sv
// Multi-cycle element-wise add/sub/rsub/pass over DIM x DIM signed matrices,
// LANES elements per beat, with wrap or saturate and a sticky overflow flag.
module mpu_elementwise #(
    parameter int DIM    = 5,
    parameter int ELEM_W = 8,
    parameter int LANES  = 5
) (
    input  logic              clk,
    input  logic              reset,
    mpu_elementwise_if.slave  bus
);
    localparam int N     = DIM * DIM;
    localparam int NW    = N * ELEM_W;
    localparam int LW    = LANES * ELEM_W;
    localparam int BEATS = N / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (N % LANES != 0) begin : g_bad_lanes
        $error("mpu_elementwise: DIM*DIM must be divisible by LANES");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   a_q, a_d;
    logic [NW-1:0]   b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic            sat_q, sat_d;
    logic [NW-1:0]   res_q, res_d;
    logic            ovf_q, ovf_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [LW-1:0]   lane_out;
    logic            lane_ovf;
    logic            last_beat;

    // Returns {overflow, stored value} for one element.
    function automatic logic [ELEM_W:0] lane_calc(
        input logic [ELEM_W-1:0] a,
        input logic [ELEM_W-1:0] b,
        input logic [1:0]        op,
        input logic              sat
    );
        logic [ELEM_W:0]   ea, eb, full;
        logic              ov;
        logic [ELEM_W-1:0] v;
        ea = {a[ELEM_W-1], a};
        eb = {b[ELEM_W-1], b};
        case (op)
            2'b00:   full = ea + eb;
            2'b01:   full = ea - eb;
            2'b10:   full = eb - ea;
            default: full = ea;
        endcase
        ov = full[ELEM_W] ^ full[ELEM_W-1];
        if (ov && sat)
            v = full[ELEM_W] ? {1'b1, {(ELEM_W-1){1'b0}}}
                             : {1'b0, {(ELEM_W-1){1'b1}}};
        else
            v = full[ELEM_W-1:0];
        return {ov, v};
    endfunction

    // Operands are shifted down each beat, so lanes always read the low bits.
    always_comb begin
        logic [ELEM_W:0] r;
        lane_out = '0;
        lane_ovf = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            r = lane_calc(a_q[l*ELEM_W +: ELEM_W], b_q[l*ELEM_W +: ELEM_W],
                          op_q, sat_q);
            lane_out[l*ELEM_W +: ELEM_W] = r[ELEM_W-1:0];
            lane_ovf = lane_ovf | r[ELEM_W];
        end
    end

    assign last_beat = (beat_q == BW'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_valid)  state_d = RUN;
            RUN:     if (last_beat)        state_d = DONE;
            DONE:    if (bus.result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.start_ready  = (state_q == IDLE);
        bus.busy         = (state_q != IDLE);
        bus.result_valid = (state_q == DONE);
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        sat_d  = sat_q;
        res_d  = res_q;
        ovf_d  = ovf_q;
        beat_d = beat_q;
        unique case (1'b1)
            (state_q == IDLE) && bus.start_valid: begin
                a_d    = bus.matrix_a;
                b_d    = bus.matrix_b;
                op_d   = bus.op;
                sat_d  = bus.sat;
                res_d  = '0;
                ovf_d  = 1'b0;
                beat_d = '0;
            end
            (state_q == RUN): begin
                a_d = a_q >> LW;
                b_d = b_q >> LW;
                res_d[beat_q*LW +: LW] = lane_out;
                ovf_d  = ovf_q | lane_ovf;
                beat_d = last_beat ? '0 : beat_q + BW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 2'b00;
            sat_q  <= 1'b0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            beat_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            sat_q  <= sat_d;
            res_q  <= res_d;
            ovf_q  <= ovf_d;
            beat_q <= beat_d;
        end
    end

    assign bus.result   = res_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_mpu_elementwise.sv
// Directed bench for mpu_elementwise: default 5x5 int8 instance plus a
// 4x4 int16 single-lane instance for the parameter sweep.
module tb_mpu_elementwise;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mpu_elementwise_if #(.DIM(5), .ELEM_W(8))  if0 ();
    mpu_elementwise_if #(.DIM(4), .ELEM_W(16)) if1 ();

    mpu_elementwise #(.DIM(5), .ELEM_W(8), .LANES(5)) u0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    mpu_elementwise #(.DIM(4), .ELEM_W(16), .LANES(1)) u1 (
        .clk(clk), .reset(reset), .bus(if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [199:0] fill8(input logic [7:0] v);
        logic [199:0] f;
        for (int k = 0; k < 25; k++) f[8*k +: 8] = v;
        return f;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic start0(input logic [199:0] a, input logic [199:0] b,
                          input logic [1:0] op, input logic sat);
        if0.matrix_a    = a;
        if0.matrix_b    = b;
        if0.op          = op;
        if0.sat         = sat;
        if0.start_valid = 1'b1;
        @(posedge clk);
        #1 if0.start_valid = 1'b0;
    endtask

    task automatic wait0(output int cyc);
        cyc = 0;
        while (!if0.result_valid && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic pop0();
        if0.result_ready = 1'b1;
        @(posedge clk);
        #1 if0.result_ready = 1'b0;
    endtask

    task automatic start1(input logic [255:0] a, input logic [255:0] b,
                          input logic [1:0] op, input logic sat);
        if1.matrix_a    = a;
        if1.matrix_b    = b;
        if1.op          = op;
        if1.sat         = sat;
        if1.start_valid = 1'b1;
        @(posedge clk);
        #1 if1.start_valid = 1'b0;
    endtask

    task automatic wait1(output int cyc);
        cyc = 0;
        while (!if1.result_valid && cyc < 60) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic pop1();
        if1.result_ready = 1'b1;
        @(posedge clk);
        #1 if1.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (if0.result !== 200'd0) begin
            failures++;
            $display("FAIL reset_result got=%0h exp=0", if0.result);
        end
        checks++;
        if (if0.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", if0.result_valid);
        end
        checks++;
        if (if0.overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got=%b exp=0", if0.overflow);
        end
        checks++;
        if (if0.start_ready !== 1'b1 || if0.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready_busy got=%b%b exp=10",
                     if0.start_ready, if0.busy);
        end
    endtask

    task automatic test_add();
        int cyc;
        do_reset();
        start0(fill8(8'd3), fill8(8'd4), 2'b00, 1'b0);
        checks++;
        if (if0.busy !== 1'b1 || if0.start_ready !== 1'b0) begin
            failures++;
            $display("FAIL add_run_flags got=%b%b exp=10",
                     if0.busy, if0.start_ready);
        end
        wait0(cyc);
        checks++;
        if (cyc !== 5) begin
            failures++;
            $display("FAIL add_latency got=%0d exp=5", cyc);
        end
        checks++;
        if (if0.result !== fill8(8'd7)) begin
            failures++;
            $display("FAIL add_result got=%h exp=%h", if0.result, fill8(8'd7));
        end
        checks++;
        if (if0.overflow !== 1'b0) begin
            failures++;
            $display("FAIL add_ovf got=%b exp=0", if0.overflow);
        end
        pop0();
        checks++;
        if (if0.result_valid !== 1'b0 || if0.result !== fill8(8'd7)) begin
            failures++;
            $display("FAIL add_after_pop got=%b/%h exp=0/%h",
                     if0.result_valid, if0.result, fill8(8'd7));
        end
    endtask

    task automatic test_sub_wrap();
        int cyc;
        logic [199:0] a, b;
        do_reset();
        a = '0;
        b = '0;
        a[7:0] = 8'h80;
        b[7:0] = 8'h01;
        start0(a, b, 2'b01, 1'b0);
        wait0(cyc);
        checks++;
        if (if0.result !== {192'd0, 8'h7F} || if0.overflow !== 1'b1) begin
            failures++;
            $display("FAIL sub_wrap got=%h/%b exp=7f/1",
                     if0.result, if0.overflow);
        end
        pop0();
        start0(a, b, 2'b10, 1'b0);
        wait0(cyc);
        checks++;
        if (if0.result !== {192'd0, 8'h81} || if0.overflow !== 1'b1) begin
            failures++;
            $display("FAIL rsub_wrap got=%h/%b exp=81/1",
                     if0.result, if0.overflow);
        end
        pop0();
        start0(fill8(8'd100), fill8(8'd100), 2'b00, 1'b0);
        wait0(cyc);
        checks++;
        if (if0.result !== fill8(8'hC8) || if0.overflow !== 1'b1) begin
            failures++;
            $display("FAIL add_wrap got=%h/%b exp=c8../1",
                     if0.result, if0.overflow);
        end
        pop0();
    endtask

    task automatic test_sat();
        int cyc;
        do_reset();
        start0(fill8(8'd100), fill8(8'd100), 2'b00, 1'b1);
        wait0(cyc);
        checks++;
        if (if0.result !== fill8(8'h7F) || if0.overflow !== 1'b1) begin
            failures++;
            $display("FAIL sat_pos got=%h/%b exp=7f../1",
                     if0.result, if0.overflow);
        end
        pop0();
        start0(fill8(8'h9C), fill8(8'd100), 2'b01, 1'b1);
        wait0(cyc);
        checks++;
        if (if0.result !== fill8(8'h80) || if0.overflow !== 1'b1) begin
            failures++;
            $display("FAIL sat_neg got=%h/%b exp=80../1",
                     if0.result, if0.overflow);
        end
        pop0();
        start0(fill8(8'h9C), fill8(8'd20), 2'b10, 1'b1);
        wait0(cyc);
        checks++;
        if (if0.result !== fill8(8'h78) || if0.overflow !== 1'b0) begin
            failures++;
            $display("FAIL sat_none got=%h/%b exp=78../0",
                     if0.result, if0.overflow);
        end
        pop0();
    endtask

    task automatic test_layout();
        int cyc;
        logic [199:0] a;
        logic [199:0] r;
        do_reset();
        for (int k = 0; k < 25; k++) a[8*k +: 8] = 8'(k);
        start0(a, fill8(8'h55), 2'b11, 1'b1);
        wait0(cyc);
        r = if0.result;
        checks++;
        if (r !== a || if0.overflow !== 1'b0) begin
            failures++;
            $display("FAIL layout_pass got=%h/%b exp=%h/0", r, if0.overflow, a);
        end
        checks++;
        if (r[8*20 +: 8] !== 8'd20) begin
            failures++;
            $display("FAIL layout_r4c0 got=%0d exp=20", r[8*20 +: 8]);
        end
        checks++;
        if (r[8*4 +: 8] !== 8'd4) begin
            failures++;
            $display("FAIL layout_r0c4 got=%0d exp=4", r[8*4 +: 8]);
        end
        pop0();
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad;
        do_reset();
        start0(fill8(8'd2), fill8(8'd5), 2'b00, 1'b0);
        wait0(cyc);
        if0.matrix_a    = fill8(8'd1);
        if0.matrix_b    = fill8(8'd1);
        if0.start_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (if0.result_valid !== 1'b1 || if0.result !== fill8(8'd7) ||
                if0.start_ready !== 1'b0)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL hold_stable got=%0d bad cycles exp=0", bad);
        end
        if0.result_ready = 1'b1;
        @(posedge clk);
        #1 if0.result_ready = 1'b0;
        checks++;
        if (if0.result_valid !== 1'b0 || if0.start_ready !== 1'b1) begin
            failures++;
            $display("FAIL done_no_accept got=%b%b exp=01",
                     if0.result_valid, if0.start_ready);
        end
        @(posedge clk);
        #1 if0.start_valid = 1'b0;
        checks++;
        if (if0.busy !== 1'b1 || if0.start_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_accept got=%b%b exp=10",
                     if0.busy, if0.start_ready);
        end
        wait0(cyc);
        checks++;
        if (cyc !== 5 || if0.result !== fill8(8'd2)) begin
            failures++;
            $display("FAIL second_op got=%0d/%h exp=5/%h",
                     cyc, if0.result, fill8(8'd2));
        end
        pop0();
    endtask

    task automatic test_reset_mid();
        do_reset();
        start0(fill8(8'd100), fill8(8'd100), 2'b00, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if (if0.overflow !== 1'b1 || if0.busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_ovf got=%b%b exp=11", if0.overflow, if0.busy);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if (if0.start_ready !== 1'b1 || if0.result_valid !== 1'b0 ||
            if0.overflow !== 1'b0 || if0.result !== 200'd0) begin
            failures++;
            $display("FAIL mid_reset got=%b%b%b/%h exp=100/0",
                     if0.start_ready, if0.result_valid, if0.overflow,
                     if0.result);
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (if0.result_valid !== 1'b0 || if0.busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_stays_idle got=%b%b exp=00",
                     if0.result_valid, if0.busy);
        end
    endtask

    task automatic test_sweep();
        int cyc;
        logic [255:0] a, b;
        do_reset();
        a = '0;
        b = '0;
        a[15:0] = 16'h7FFF;
        b[15:0] = 16'h0001;
        start1(a, b, 2'b00, 1'b1);
        wait1(cyc);
        checks++;
        if (cyc !== 16) begin
            failures++;
            $display("FAIL sweep_latency got=%0d exp=16", cyc);
        end
        checks++;
        if (if1.result !== {240'd0, 16'h7FFF} || if1.overflow !== 1'b1) begin
            failures++;
            $display("FAIL sweep_sat got=%h/%b exp=7fff/1",
                     if1.result, if1.overflow);
        end
        pop1();
        start1(a, b, 2'b00, 1'b0);
        wait1(cyc);
        checks++;
        if (if1.result !== {240'd0, 16'h8000} || if1.overflow !== 1'b1) begin
            failures++;
            $display("FAIL sweep_wrap got=%h/%b exp=8000/1",
                     if1.result, if1.overflow);
        end
        pop1();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        if0.start_valid  = 1'b0;
        if0.op           = 2'b00;
        if0.sat          = 1'b0;
        if0.matrix_a     = '0;
        if0.matrix_b     = '0;
        if0.result_ready = 1'b0;
        if1.start_valid  = 1'b0;
        if1.op           = 2'b00;
        if1.sat          = 1'b0;
        if1.matrix_a     = '0;
        if1.matrix_b     = '0;
        if1.result_ready = 1'b0;
        test_reset();
        test_add();
        test_sub_wrap();
        test_sat();
        test_layout();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
